// File: rtl/uart_rx_mmio_pkg.sv
// Shared constants for the UART receive block: console MMIO map, STATUS bit positions, RX FSM states.
// Ports: none (package). Imported by uart_rx_core and uart_rx_mmio.
// Config: UART_RX_PARITY_EN selects 8E1 framing in the files that import this package.
package uart_rx_mmio_pkg;

  localparam logic [31:0] HALT_ADDR    = 32'hf0000000;
  localparam logic [31:0] UART_TX_ADDR = 32'hf0000100;
  localparam logic [31:0] UART_RX_BASE = 32'hf0000200;

  localparam int ST_NONEMPTY = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_FRAME    = 2;
  localparam int ST_OVERRUN  = 3;
  localparam int ST_PARITY   = 4;

  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_t;

  // Window decode: only the upper 28 address bits select the block.
  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:4] == base[31:4];
  endfunction

endpackage

// File: rtl/uart_rx_mmio_if.sv
// Processor MMIO read/write bus for the UART receiver (mem_oe/mem_addr/mem_we in, rdata/valid out).
// Ports: oe, addr[31:0], we[3:0] from the master; rdata[31:0], valid from the slave.
// Config: none.
interface uart_rx_mmio_if;
  logic        oe;
  logic [31:0] addr;
  logic [3:0]  we;
  logic [31:0] rdata;
  logic        valid;

  modport master (output oe, addr, we, input rdata, valid);
  modport slave  (input oe, addr, we, output rdata, valid);
endinterface

// File: rtl/uart_rx_mmio_core.sv
// uart_rx_core: 2-flop synchroniser plus bit-level RX FSM; emits one-cycle registered strobes per frame.
// Ports: clk, rst (sync, active high), rxd (async serial in) -> rx_byte, byte_stb, frame_err_stb, parity_err_stb.
// Config: UART_RX_PARITY_EN adds an even-parity bit between data and stop (8E1); otherwise 8N1.
module uart_rx_core
  import uart_rx_mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       byte_stb,
  output logic       frame_err_stb,
  output logic       parity_err_stb
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT);

  logic            sync1, sync2, sync_prev;
  rx_state_t       state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            tick;
`ifdef UART_RX_PARITY_EN
  logic            par_ok;
`endif

  // Idle-high reset so a reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync1     <= rxd;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  // A load of N puts the sample exactly N cycles later, so bit spacing is CLKS_PER_BIT.
  assign tick = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      shreg          <= '0;
      rx_byte        <= '0;
      byte_stb       <= 1'b0;
      frame_err_stb  <= 1'b0;
      parity_err_stb <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_ok         <= 1'b1;
`endif
    end else begin
      byte_stb       <= 1'b0;
      frame_err_stb  <= 1'b0;
      parity_err_stb <= 1'b0;
      if (state != S_IDLE && !tick) cnt <= cnt - CW'(1);
      case (state)
        S_IDLE: begin
          if (!sync2 && sync_prev) begin
            cnt   <= HALF_BIT;
            state <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            if (sync2) begin
              state <= S_IDLE;  // false start
            end else begin
              cnt     <= FULL_BIT;
              bit_idx <= '0;
              state   <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            shreg   <= {sync2, shreg[7:1]};
            cnt     <= FULL_BIT;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            par_ok <= (sync2 == ^shreg);  // even parity
            cnt    <= FULL_BIT;
            state  <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          // Decide at mid-stop-bit and rearm immediately for the next start edge.
          if (tick) begin
            state <= S_IDLE;
            if (!sync2) begin
              frame_err_stb <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (!par_ok) begin
              parity_err_stb <= 1'b1;
`endif
            end else begin
              byte_stb <= 1'b1;
              rx_byte  <= shreg;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio: UART receiver with byte FIFO exposed as a registered MMIO read responder (DATA at +0, STATUS at +4).
// Ports: clk, rst (sync, active high), uart_rxd, bus (uart_rx_mmio_if.slave: oe/addr/we in, rdata/valid out), rx_ready.
// Config: UART_RX_PARITY_EN enables 8E1 framing and the sticky parity_err flag (STATUS bit4); otherwise bit4 reads 0.
module uart_rx_mmio
  import uart_rx_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = UART_RX_BASE,
  parameter int          CLKS_PER_BIT   = 868,
  parameter int          FIFO_DEPTH_LOG = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           uart_rxd,
  uart_rx_mmio_if.slave  bus,
  output logic           rx_ready
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG;

  logic [7:0]                rx_byte;
  logic                      byte_stb, frame_err_stb, parity_err_stb;
  logic [7:0]                mem [DEPTH];
  logic [FIFO_DEPTH_LOG-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_LOG:0]   count;
  logic                      frame_err, overrun, parity_err;
  logic                      hit, is_wr, full, non_empty, pop, push, clr;
  logic [31:0]               status;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
    .clk            (clk),
    .rst            (rst),
    .rxd            (uart_rxd),
    .rx_byte        (rx_byte),
    .byte_stb       (byte_stb),
    .frame_err_stb  (frame_err_stb),
    .parity_err_stb (parity_err_stb)
  );

  assign full      = (count == (FIFO_DEPTH_LOG+1)'(DEPTH));
  assign non_empty = (count != '0);
  assign rx_ready  = non_empty;

  assign hit   = bus.oe && in_window(bus.addr, BASE_ADDR);
  assign is_wr = |bus.we;
  assign pop   = hit && !is_wr && bus.addr[3:0] == OFF_DATA && non_empty;
  assign clr   = hit && is_wr && bus.addr[3:0] == OFF_STATUS;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push  = byte_stb && (!full || pop);

  always_comb begin
    status              = '0;
    status[ST_NONEMPTY] = non_empty;
    status[ST_FULL]     = full;
    status[ST_FRAME]    = frame_err;
    status[ST_OVERRUN]  = overrun;
`ifdef UART_RX_PARITY_EN
    status[ST_PARITY]   = parity_err;
`else
    status[ST_PARITY]   = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
      bus.valid  <= 1'b0;
      bus.rdata  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      // Set wins over a same-cycle clear.
      frame_err  <= (frame_err  && !clr) || frame_err_stb;
      overrun    <= (overrun    && !clr) || (byte_stb && !push);
      parity_err <= (parity_err && !clr) || parity_err_stb;

      bus.valid <= 1'b0;
      bus.rdata <= '0;
      if (hit && !is_wr) begin
        bus.valid <= 1'b1;
        case (bus.addr[3:0])
          OFF_DATA:   bus.rdata <= non_empty ? {24'h0, mem[rd_ptr]} : 32'hFFFF_FFFF;
          OFF_STATUS: bus.rdata <= status;
          default:    bus.rdata <= '0;
        endcase
      end
    end
  end

endmodule
